// File: rtl/sram_ctrl_param.sv
// Purpose: moves one DATA_W CPU word to/from a 16-bit asynchronous SRAM as N little-endian beats.
// Latency: request at cycle 0, ACCESS cycles 1..N*T, ready in DONE at cycle N*T+1 (cycle 1 if out of range).
// Backpressure: ready stays low while a request is pending or in flight; the CPU holds its strobe until ready.
module sram_ctrl_param #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                w_en,
    input  logic                r_en,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                err,
    output logic [DATA_W-1:0]   read_data,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);
    localparam int N  = DATA_W / SRAM_DW;
    localparam int T  = WAIT_CYCLES + 1;
    localparam int B  = $clog2(DATA_W / 8);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(T);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BW-1:0]        beat;
    logic [CW-1:0]        cyc;
    logic                 op_rd;
    logic                 err_q;
    logic [SRAM_AW-1:0]   word_base;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W/8-1:0]  be_q;
    logic [DATA_W-1:0]    rd_buf;
    logic [DATA_W-1:0]    rd_merge;
    logic                 dq_oe;

    logic                 req;
    logic [63:0]          offset;
    logic [63:0]          last_beat;
    logic                 in_range;
    logic                 beat_end;
    logic                 last_end;

    // Range is checked on the whole word: its highest beat must still fit the SRAM.
    assign req       = w_en | r_en;
    assign offset    = 64'(address - 32'(BASE_ADDR)) >> B;
    assign last_beat = offset * 64'(N) + 64'(N - 1);
    assign in_range  = (address >= 32'(BASE_ADDR)) && (last_beat < (64'd1 << SRAM_AW));
    assign beat_end  = (cyc == CW'(T - 1));
    assign last_end  = beat_end && (beat == BW'(N - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: out-of-range requests skip the SRAM entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = in_range ? ACCESS : DONE;
            ACCESS:  if (last_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture in IDLE and beat/cycle counting in ACCESS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat      <= '0;
            cyc       <= '0;
            op_rd     <= 1'b0;
            err_q     <= 1'b0;
            word_base <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else if (state == IDLE) begin
            beat <= '0;
            cyc  <= '0;
            if (req) begin
                op_rd     <= r_en;
                err_q     <= !in_range;
                word_base <= SRAM_AW'(offset * 64'(N));
                wdata_q   <= write_data;
                be_q      <= be;
            end
        end else if (state == ACCESS) begin
            if (beat_end) begin
                cyc  <= '0;
                beat <= beat + 1'b1;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end

    // Current beat's SRAM data merged into the partially assembled read word
    always_comb begin
        rd_merge = rd_buf;
        rd_merge[beat*SRAM_DW +: SRAM_DW] = SRAM_DQ;
    end

    // Read assembly: slices land in rd_buf; read_data only changes when a read completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_buf    <= '0;
            read_data <= '0;
        end else if (state == ACCESS && op_rd && beat_end) begin
            rd_buf <= rd_merge;
            if (last_end) read_data <= rd_merge;
        end
    end

    // Output decode from registered state; WE_N rises in the last cycle of a write beat
    always_comb begin
        ready     = 1'b0;
        err       = 1'b0;
        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe     = 1'b0;
        case (state)
            IDLE: ready = !req;
            ACCESS: begin
                SRAM_ADDR = word_base + SRAM_AW'(beat);
                SRAM_CE_N = 1'b0;
                if (op_rd) begin
                    SRAM_OE_N = 1'b0;
                    SRAM_UB_N = 1'b0;
                    SRAM_LB_N = 1'b0;
                end else begin
                    SRAM_WE_N = beat_end;
                    SRAM_UB_N = !be_q[2*beat+1];
                    SRAM_LB_N = !be_q[2*beat];
                    dq_oe     = 1'b1;
                end
            end
            DONE: begin
                ready = 1'b1;
                err   = err_q;
            end
            default: ;
        endcase
    end

    // DQ is driven only through write beats, including the WE_N rising edge
    assign SRAM_DQ = dq_oe ? wdata_q[beat*SRAM_DW +: SRAM_DW] : 'z;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Purpose: randomized and directed checks of sram_ctrl_param against a byte-level word memory model.
// Latency: expected ready cycle computed as N*T+1 (or 1 when out of range).
// Backpressure: strobes held until ready is seen, then dropped.
module tb_sram_ctrl_param;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default-parameter instance (32-bit word, 2 wait cycles)
    logic        w_en0, r_en0, ready0, err0;
    logic [31:0] addr0, wd0, rd0;
    logic [3:0]  be0;
    logic [17:0] sa0;
    wire  [15:0] dq0;
    logic        we0, oe0, ce0, ub0, lb0;

    // Swept instance (64-bit word, 1 wait cycle)
    logic        w_en1, r_en1, ready1, err1;
    logic [31:0] addr1;
    logic [63:0] wd1, rd1;
    logic [7:0]  be1;
    logic [17:0] sa1;
    wire  [15:0] dq1;
    logic        we1, oe1, ce1, ub1, lb1;

    sram_ctrl_param dut0 (
        .clk(clk), .reset(reset), .w_en(w_en0), .r_en(r_en0), .address(addr0),
        .write_data(wd0), .be(be0), .ready(ready0), .err(err0), .read_data(rd0),
        .SRAM_ADDR(sa0), .SRAM_DQ(dq0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0),
        .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_ctrl_param #(.DATA_W(64), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .w_en(w_en1), .r_en(r_en1), .address(addr1),
        .write_data(wd1), .be(be1), .ready(ready1), .err(err1), .read_data(rd1),
        .SRAM_ADDR(sa1), .SRAM_DQ(dq1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1),
        .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // Behavioural asynchronous SRAMs
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];
    assign dq0 = (!ce0 && !oe0) ? mem0[sa0] : 16'hzzzz;
    assign dq1 = (!ce1 && !oe1) ? mem1[sa1] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce0 && !we0) begin
            if (!lb0) mem0[sa0][7:0]  <= dq0[7:0];
            if (!ub0) mem0[sa0][15:8] <= dq0[15:8];
        end
        if (!ce1 && !we1) begin
            if (!lb1) mem1[sa1][7:0]  <= dq1[7:0];
            if (!ub1) mem1[sa1][15:8] <= dq1[15:8];
        end
    end

    // Pin monitor
    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
        logic        ub;
        logic        lb;
    } wl_t;
    wl_t wlog[$];
    int  oe_cnt = 0, ce_cnt = 0, we1_cnt = 0, excl_bad = 0;

    always @(negedge clk) begin
        if (!we0 && !ce0) wlog.push_back('{sa0, dq0, ub0, lb0});
        if (!oe0) oe_cnt++;
        if (!ce0) ce_cnt++;
        if (!we1 && !ce1) we1_cnt++;
        if ((!oe0 && !we0) || (!oe1 && !we1)) excl_bad++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: word memory keyed by (instance, word offset)
    logic [63:0] refm [longint];
    logic [63:0] exp_rd [2];
    int          g_wl0, g_ce0;

    task automatic opx(input int u, input bit w, input bit r, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] b);
        int          nb, n, t, lat, oe0s, we1s;
        longint      off, key;
        bit          inr, e, seen;
        logic [63:0] cur;
        nb  = u ? 8 : 4;
        n   = u ? 4 : 2;
        t   = u ? 2 : 3;
        inr = (a >= 1024);
        off = inr ? (longint'(a) - 1024) / nb : 0;
        inr = inr && (off * n + n - 1 < 262144);
        key = (longint'(u) << 40) + off;

        @(posedge clk); #1;
        g_wl0 = wlog.size(); g_ce0 = ce_cnt; oe0s = oe_cnt; we1s = we1_cnt;
        if (u == 0) begin
            w_en0 = w; r_en0 = r; addr0 = a; wd0 = d[31:0]; be0 = b[3:0];
        end else begin
            w_en1 = w; r_en1 = r; addr1 = a; wd1 = d; be1 = b;
        end
        seen = 0; lat = 0; e = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (u ? ready1 : ready0) begin
                seen = 1; lat = k; e = u ? err1 : err0;
            end
        end
        chk("ready_seen", seen, 1);
        chk("latency", lat, inr ? n * t + 1 : 1);
        chk("err", e, !inr);

        if (inr && r) begin
            exp_rd[u] = refm.exists(key) ? refm[key] : 64'd0;
        end else if (inr && w) begin
            cur = refm.exists(key) ? refm[key] : 64'd0;
            for (int i = 0; i < nb; i++)
                if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
            refm[key] = cur;
        end
        chk("read_data", u ? rd1 : {32'd0, rd0}, exp_rd[u]);
        if (u == 0) begin
            chk("oe_cycles", oe_cnt - oe0s, (inr && r) ? n * t : 0);
            chk("we_cycles", wlog.size() - g_wl0, (inr && !r && w) ? n * (t - 1) : 0);
        end else begin
            chk("we1_cycles", we1_cnt - we1s, (inr && !r && w) ? n * (t - 1) : 0);
        end

        @(posedge clk); #1;
        w_en0 = 0; r_en0 = 0; w_en1 = 0; r_en1 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [63:0] d;
        int          sel, kind;

        reset = 1;
        w_en0 = 0; r_en0 = 0; addr0 = 0; wd0 = 0; be0 = 0;
        w_en1 = 0; r_en1 = 0; addr1 = 0; wd1 = 0; be1 = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready0, 1);
        chk("rst_err", err0, 0);
        chk("rst_rd", rd0, 0);
        chk("rst_pins", {ce0, oe0, we0, ub0, lb0}, 5'b11111);
        chk("rst_addr", sa0, 0);
        chk("rst_ready1", ready1, 1);
        reset = 0;

        // Write then read at default parameters
        opx(0, 1, 0, 1028, 64'hDEADBEEF, 8'hF);
        chk("w1_b0_addr", wlog[g_wl0].a, 2);
        chk("w1_b0_addr2", wlog[g_wl0+1].a, 2);
        chk("w1_b0_dq", wlog[g_wl0].d, 16'hBEEF);
        chk("w1_b1_addr", wlog[g_wl0+2].a, 3);
        chk("w1_b1_dq", wlog[g_wl0+3].d, 16'hDEAD);
        opx(0, 0, 1, 1028, 0, 0);
        chk("rd1_const", rd0, 32'hDEADBEEF);

        // Byte enables
        opx(0, 1, 0, 1028, 64'h11223344, 8'h6);
        chk("be_b0_ublb", {wlog[g_wl0].ub, wlog[g_wl0].lb}, 2'b01);
        chk("be_b1_ublb", {wlog[g_wl0+2].ub, wlog[g_wl0+2].lb}, 2'b10);
        opx(0, 0, 1, 1028, 0, 0);
        chk("be_rd_const", rd0, 32'hDE2233EF);

        // Out of range
        opx(0, 0, 1, 1000, 0, 0);
        chk("oor_ce_idle", ce_cnt - g_ce0, 0);
        chk("oor_rd_hold", rd0, 32'hDE2233EF);

        // Both strobes: read wins
        opx(0, 1, 1, 1028, 64'h55555555, 8'hF);

        // Reset in the middle of beat 1 of a write
        @(posedge clk); #1;
        w_en0 = 1; addr0 = 1040; wd0 = 32'hCAFEF00D; be0 = 4'hF;
        repeat (5) @(negedge clk);
        chk("mid_we_low", we0, 0);
        chk("mid_addr", sa0, 9);
        #1 reset = 1;
        #1;
        chk("rst_mid_we", we0, 1);
        chk("rst_mid_ce", ce0, 1);
        chk("rst_mid_rd", rd0, 0);
        chk("rst_mid_addr", sa0, 0);
        w_en0 = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        @(posedge clk); #1 reset = 0;
        opx(0, 1, 0, 1040, 64'h0BADC0DE, 8'hF);
        opx(0, 0, 1, 1040, 0, 0);

        // Randomized traffic on a small window plus the top valid word
        for (int i = 0; i < 8; i++) opx(0, 1, 0, 1024 + 4 * i, {32'd0, $urandom}, 8'hF);
        opx(0, 1, 0, 525308, {32'd0, $urandom}, 8'hF);
        chk("top_addr", wlog[g_wl0+2].a, 262143);
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = $urandom_range(0, 1023);
            else if (sel == 1) a = 525312 + $urandom_range(0, 4095);
            else if (sel == 2) a = 525308 + $urandom_range(0, 3);
            else               a = 1024 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            d = {32'd0, $urandom};
            opx(0, kind != 1, kind != 0, a, d, 8'($urandom_range(0, 15)));
        end

        // Swept parameters: 64-bit word, 4 beats x 2 cycles
        opx(1, 1, 0, 525304, {$urandom, $urandom}, 8'hFF);
        opx(1, 0, 1, 525304, 0, 0);
        opx(1, 1, 0, 525304, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        opx(1, 0, 1, 525304, 0, 0);
        opx(1, 0, 1, 525312, 0, 0);
        opx(1, 1, 0, 1064, {$urandom, $urandom}, 8'hFF);
        opx(1, 0, 1, 1064, 0, 0);

        chk("oe_we_exclusive", excl_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
